// File: rtl/lcd_write_arbiter.sv
// lcd_write_arbiter
//   Shares one LCD controller byte port between two requesters. In IDLE a
//   requester is granted only while the controller reports ready. The grant
//   latches the winner's byte, acks the winner and raises a one-cycle
//   data-ready strobe (ISSUE). The FSM then follows the controller's ready
//   flag low (WAIT_BUSY) and high again (WAIT_DONE) before it returns to IDLE.
//   A watchdog returns the FSM to IDLE if the controller stops responding.
//
//   Configuration macro: LCD_WRITE_ARBITER_FIXED_PRIO_EN
//     undefined (default) - round-robin between requesters
//     defined             - requester 0 always wins a tie
//
// Ports
//   Clock            system clock, rising edge
//   Reset            asynchronous active-low reset
//   iReq0/iReq1      level requests, held until the matching ack
//   iData0/iData1    request bytes
//   oAck0/oAck1      one-cycle pulse: byte latched
//   iLCD_Ready       controller ready-for-data flag
//   oLCD_Data        latched byte presented to the controller
//   oLCD_Data_Ready  one-cycle strobe to the controller
//   oBusy            high whenever the FSM is not in IDLE
//   oOwner           current or most recently granted requester
//   oTimeout         one-cycle pulse when the watchdog fires
module lcd_write_arbiter #(
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iReq0,
  input  logic [DATA_WIDTH-1:0] iData0,
  output logic                  oAck0,
  input  logic                  iReq1,
  input  logic [DATA_WIDTH-1:0] iData1,
  output logic                  oAck1,
  input  logic                  iLCD_Ready,
  output logic [DATA_WIDTH-1:0] oLCD_Data,
  output logic                  oLCD_Data_Ready,
  output logic                  oBusy,
  output logic                  oOwner,
  output logic                  oTimeout
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_e;

  // Watchdog fires when the counter would reach this value.
  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  state_e                state_q;
  logic                  ack0_q;
  logic                  ack1_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  strobe_q;
  logic                  busy_q;
  logic                  owner_q;
  logic                  timeout_q;
  logic [15:0]           wd_q;

  logic                  grant_d;
  logic                  win_d;
  logic [15:0]           wd_d;
  logic                  wd_expire_d;

`ifndef LCD_WRITE_ARBITER_FIXED_PRIO_EN
  // 1 = requester 1 wins the next tie.
  logic                  ptr_q;
`endif

  // Grant qualification, winner selection and watchdog next value.
  always_comb begin
    grant_d     = iLCD_Ready & (iReq0 | iReq1);
    wd_d        = wd_q + 16'd1;
    wd_expire_d = (wd_d == WD_LIMIT);
`ifdef LCD_WRITE_ARBITER_FIXED_PRIO_EN
    if (iReq0) begin
      win_d = 1'b0;
    end else begin
      win_d = iReq1;
    end
`else
    if (iReq0 && iReq1) begin
      win_d = ptr_q;
    end else begin
      win_d = iReq1;
    end
`endif
  end

  // Arbiter FSM with registered outputs and watchdog.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= S_IDLE;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      data_q    <= '0;
      strobe_q  <= 1'b0;
      busy_q    <= 1'b0;
      owner_q   <= 1'b0;
      timeout_q <= 1'b0;
      wd_q      <= 16'd0;
`ifndef LCD_WRITE_ARBITER_FIXED_PRIO_EN
      ptr_q     <= 1'b0;
`endif
    end else begin
      // Pulse outputs default low; only the transitions below raise them.
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      strobe_q  <= 1'b0;
      timeout_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant_d) begin
            state_q  <= S_ISSUE;
            busy_q   <= 1'b1;
            data_q   <= win_d ? iData1 : iData0;
            owner_q  <= win_d;
            ack0_q   <= ~win_d;
            ack1_q   <= win_d;
            strobe_q <= 1'b1;
            wd_q     <= 16'd0;
`ifndef LCD_WRITE_ARBITER_FIXED_PRIO_EN
            ptr_q    <= ~win_d;
`endif
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_ISSUE: begin
          state_q <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY, S_WAIT_DONE: begin
          wd_q <= wd_d;
          // Completion takes precedence over a watchdog expiry on the same edge.
          if ((state_q == S_WAIT_DONE) && iLCD_Ready) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (wd_expire_d) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
          end else if ((state_q == S_WAIT_BUSY) && !iLCD_Ready) begin
            state_q <= S_WAIT_DONE;
          end else begin
            state_q <= state_q;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign oAck0           = ack0_q;
  assign oAck1           = ack1_q;
  assign oLCD_Data       = data_q;
  assign oLCD_Data_Ready = strobe_q;
  assign oBusy           = busy_q;
  assign oOwner          = owner_q;
  assign oTimeout        = timeout_q;

endmodule
